spi_miso_rx_capture: RTL and testbench

Parametrised successor to the master's 8:1 MISO selector. Selects one of NUM_SLAVES MISO lines, latching the select at frame start. Synchronises the line and shifts DATA_W bits in on master-supplied sample strobes, then presents a received word with a one-cycle valid pulse. Sits between the slave MISO pins and the SPI master's RX data path.

---
 rtl/spi_rx_pkg.sv | 15 +
 rtl/spi_sync_ff.sv | 20 ++
 rtl/spi_miso_rx_capture.sv | 133 +++++++++++++
 tb/tb_spi_miso_rx_capture.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// Shared types and reset constants for the SPI MISO receive capture block.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } rx_state_t;

  localparam rx_state_t RST_STATE   = IDLE;
  localparam logic      RST_VALID   = 1'b0;
  localparam logic      RST_SEL_ERR = 1'b0;
  localparam logic      RST_BIT     = 1'b0;

endpackage

// File: rtl/spi_sync_ff.sv
// Single-bit multi-flop synchroniser with asynchronous active-high reset.
module spi_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_miso_rx_capture.sv
// Selects one slave MISO line, synchronises it and shifts in DATA_W bits on master strobes.
// Optional MOSI->MISO self-test source enabled by defining SPI_MISO_LOOPBACK_EN.
module spi_miso_rx_capture
  import spi_rx_pkg::*;
#(
  parameter  int NUM_SLAVES  = 8,
  parameter  int DATA_W      = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int SEL_W       = $clog2(NUM_SLAVES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SLAVES-1:0] slave_miso_lines_in,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic                  frame_start,
  input  logic                  frame_abort,
  input  logic                  sample_stb,
  input  logic                  msb_first,
`ifdef SPI_MISO_LOOPBACK_EN
  input  logic                  loopback_in,
  input  logic                  loopback_sel,
`endif
  output logic [DATA_W-1:0]     rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic [SEL_W-1:0]      sel_active,
  output logic                  sel_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_t               state, state_next;
  logic [SYNC_STAGES-1:0]  stb_line;
  logic [DATA_W-1:0]       shreg;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    msb_q;
  logic                    miso_src;
  logic                    miso_sync;
  logic                    sel_ok;
  logic                    start_accept;
  logic                    start_reject;
  logic                    stb_out;

`ifdef SPI_MISO_LOOPBACK_EN
  logic lb_sel_q;
  assign miso_src = lb_sel_q ? loopback_in : slave_miso_lines_in[sel_active];
`else
  assign miso_src = slave_miso_lines_in[sel_active];
`endif

  spi_sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (miso_src),
    .q  (miso_sync)
  );

  assign sel_ok       = int'(sel_in) < NUM_SLAVES;
  assign start_accept = (state == IDLE) && frame_start && !frame_abort && sel_ok;
  assign start_reject = (state == IDLE) && frame_start && !frame_abort && !sel_ok;
  // The delayed strobe lines up with the synchronised copy of the bit it was meant to sample.
  assign stb_out      = stb_line[SYNC_STAGES-1] && (state == SHIFT);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RST_STATE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (frame_abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_accept) state_next = SHIFT;
        SHIFT:   if (stb_out && (bit_cnt == LAST_BIT)) state_next = DRAIN;
        DRAIN:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_line   <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      msb_q      <= RST_BIT;
      rx_data    <= '0;
      rx_valid   <= RST_VALID;
      sel_active <= '0;
      sel_err    <= RST_SEL_ERR;
`ifdef SPI_MISO_LOOPBACK_EN
      lb_sel_q   <= RST_BIT;
`endif
    end else begin
      rx_valid <= 1'b0;
      if (frame_abort) begin
        stb_line <= '0;
        bit_cnt  <= '0;
      end else begin
        stb_line <= {stb_line[SYNC_STAGES-2:0], sample_stb && (state == SHIFT)};
        if (start_accept) begin
          sel_active <= sel_in;
          msb_q      <= msb_first;
          shreg      <= '0;
          bit_cnt    <= '0;
          sel_err    <= 1'b0;
          stb_line   <= '0;
`ifdef SPI_MISO_LOOPBACK_EN
          lb_sel_q   <= loopback_sel;
`endif
        end else if (start_reject) begin
          sel_err <= 1'b1;
        end
        if (stb_out) begin
          if (msb_q) shreg <= {shreg[DATA_W-2:0], miso_sync};
          else       shreg <= {miso_sync, shreg[DATA_W-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (state == DRAIN) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_miso_rx_capture.sv
// Directed scoreboard bench for spi_miso_rx_capture (6 slaves, 8-bit words, 2 sync stages).
module tb_spi_miso_rx_capture;

  localparam int NUM_SLAVES  = 6;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int SEL_W       = $clog2(NUM_SLAVES);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_SLAVES-1:0] slave_miso_lines_in = '0;
  logic [SEL_W-1:0]      sel_in = '0;
  logic                  frame_start = 1'b0;
  logic                  frame_abort = 1'b0;
  logic                  sample_stb = 1'b0;
  logic                  msb_first = 1'b0;
  logic                  loopback_in = 1'b0;
  logic                  loopback_sel = 1'b0;
  logic [DATA_W-1:0]     rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic [SEL_W-1:0]      sel_active;
  logic                  sel_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcount = 0;
  int valid_cyc = 0;
  int last_stb_cyc = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_word;

  spi_miso_rx_capture #(
    .NUM_SLAVES (NUM_SLAVES),
    .DATA_W     (DATA_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .slave_miso_lines_in(slave_miso_lines_in),
    .sel_in             (sel_in),
    .frame_start        (frame_start),
    .frame_abort        (frame_abort),
    .sample_stb         (sample_stb),
    .msb_first          (msb_first),
`ifdef SPI_MISO_LOOPBACK_EN
    .loopback_in        (loopback_in),
    .loopback_sel       (loopback_sel),
`endif
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .busy               (busy),
    .sel_active         (sel_active),
    .sel_err            (sel_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rx_valid pops the word expected for the frame that produced it.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      vcount++;
      valid_cyc = cyc;
      if (exp_q.size() == 0) check_output("unexpected_valid", 32'd1, 32'd0);
      else check_output("rx_data_word", 32'(rx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int sel, input logic msb, input logic lb);
    sel_in       = SEL_W'(sel);
    msb_first    = msb;
    loopback_sel = lb;
    frame_start  = 1'b1;
    tick(1);
    frame_start  = 1'b0;
  endtask

  // Drives nbits of word on one line; optional toggling of the other lines, an
  // inverted decoy on another slave, or the loopback input instead of a slave line.
  task automatic send_bits(input int slave, input logic [DATA_W-1:0] word, input logic msb,
                           input int nbits, input int first, input int gap,
                           input logic toggle, input int decoy, input logic lb);
    logic b;
    for (int i = first; i < first + nbits; i++) begin
      b = msb ? word[DATA_W-1-i] : word[i];
      if (toggle) slave_miso_lines_in = ~slave_miso_lines_in;
      if (lb) begin
        loopback_in = b;
        slave_miso_lines_in = '0;
      end else begin
        slave_miso_lines_in[slave] = b;
      end
      if (decoy >= 0) slave_miso_lines_in[decoy] = ~b;
      sample_stb   = 1'b1;
      last_stb_cyc = cyc;
      tick(1);
      sample_stb = 1'b0;
      if (gap > 1 && i != first + nbits - 1) tick(gap - 1);
    end
  endtask

  task automatic wait_valid(input string tag, input int snap, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (vcount > snap) break;
      tick(1);
    end
    check_output(tag, 32'(vcount > snap), 32'd1);
  endtask

  initial begin
    int snap;
    $display("[TB] start");
    tick(2);
    rst = 1'b0;
    tick(1);
    check_output("reset_rx_data", 32'(rx_data), 32'd0);
    check_output("reset_rx_valid", 32'(rx_valid), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_sel_active", 32'(sel_active), 32'd0);
    check_output("reset_sel_err", 32'(sel_err), 32'd0);

    // Slave 5, 0xA5 MSB first, strobes 4 clk apart
    apply_stimulus(5, 1'b1, 1'b0);
    check_output("t1_busy", 32'(busy), 32'd1);
    snap = vcount;
    exp_q.push_back(8'hA5);
    send_bits(5, 8'hA5, 1'b1, 8, 0, 4, 1'b0, -1, 1'b0);
    wait_valid("t1_valid_timeout", snap, 20);
    check_output("t1_latency", 32'(valid_cyc - last_stb_cyc), 32'(SYNC_STAGES + 2));
    check_output("t1_sel_active", 32'(sel_active), 32'd5);
    check_output("t1_busy_after", 32'(busy), 32'd0);
    check_output("t1_valid_pulse", 32'(rx_valid), 32'd0);
    check_output("t1_one_valid", 32'(vcount - snap), 32'd1);

    // Slave 2, 0x3C LSB first, other lines toggling
    apply_stimulus(2, 1'b0, 1'b0);
    snap = vcount;
    exp_q.push_back(8'h3C);
    send_bits(2, 8'h3C, 1'b0, 8, 0, 4, 1'b1, -1, 1'b0);
    wait_valid("t2_valid_timeout", snap, 20);
    check_output("t2_rx_data", 32'(rx_data), 32'h3C);

    // Out-of-range select rejected, then a good frame
    apply_stimulus(7, 1'b1, 1'b0);
    check_output("t3_sel_err", 32'(sel_err), 32'd1);
    check_output("t3_busy", 32'(busy), 32'd0);
    snap = vcount;
    send_bits(1, 8'hFF, 1'b1, 8, 0, 2, 1'b0, -1, 1'b0);
    tick(10);
    check_output("t3_no_valid", 32'(vcount - snap), 32'd0);
    check_output("t3_sel_err_held", 32'(sel_err), 32'd1);
    apply_stimulus(1, 1'b1, 1'b0);
    check_output("t3_sel_err_clr", 32'(sel_err), 32'd0);
    exp_q.push_back(8'h5A);
    send_bits(1, 8'h5A, 1'b1, 8, 0, 3, 1'b0, -1, 1'b0);
    wait_valid("t3_valid_timeout", snap, 20);
    check_output("t3_rx_data", 32'(rx_data), 32'h5A);
    last_word = 8'h5A;

    // Abort after the 4th strobe, then a full 0x81 frame
    apply_stimulus(0, 1'b1, 1'b0);
    snap = vcount;
    send_bits(0, 8'h81, 1'b1, 4, 0, 4, 1'b0, -1, 1'b0);
    tick(3);
    frame_abort = 1'b1;
    tick(1);
    frame_abort = 1'b0;
    check_output("t4_busy_abort", 32'(busy), 32'd0);
    tick(10);
    check_output("t4_no_valid", 32'(vcount - snap), 32'd0);
    check_output("t4_rx_data_held", 32'(rx_data), 32'(last_word));
    apply_stimulus(0, 1'b1, 1'b0);
    exp_q.push_back(8'h81);
    send_bits(0, 8'h81, 1'b1, 8, 0, 4, 1'b0, -1, 1'b0);
    wait_valid("t4_valid_timeout", snap, 20);
    check_output("t4_rx_data", 32'(rx_data), 32'h81);

    // Mid-frame sel_in change and restart ignored; slave 4 carries an inverted decoy
    apply_stimulus(3, 1'b1, 1'b0);
    snap = vcount;
    exp_q.push_back(8'h6B);
    send_bits(3, 8'h6B, 1'b1, 3, 0, 3, 1'b0, 4, 1'b0);
    sel_in = 3'd4;
    msb_first = 1'b0;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    send_bits(3, 8'h6B, 1'b1, 5, 3, 3, 1'b0, 4, 1'b0);
    wait_valid("t5_valid_timeout", snap, 20);
    tick(10);
    check_output("t5_one_valid", 32'(vcount - snap), 32'd1);
    check_output("t5_sel_active", 32'(sel_active), 32'd3);
    check_output("t5_rx_data", 32'(rx_data), 32'h6B);
    sel_in = 3'd2;
    frame_start = 1'b1;
    frame_abort = 1'b1;
    tick(1);
    frame_start = 1'b0;
    frame_abort = 1'b0;
    check_output("t5_abort_start_busy", 32'(busy), 32'd0);
    check_output("t5_abort_start_sel", 32'(sel_active), 32'd3);

    // Back-to-back strobes on consecutive cycles
    apply_stimulus(4, 1'b0, 1'b0);
    snap = vcount;
    exp_q.push_back(8'hC3);
    send_bits(4, 8'hC3, 1'b0, 8, 0, 1, 1'b1, -1, 1'b0);
    wait_valid("t5b_valid_timeout", snap, 20);
    check_output("t5b_latency", 32'(valid_cyc - last_stb_cyc), 32'(SYNC_STAGES + 2));

`ifdef SPI_MISO_LOOPBACK_EN
    apply_stimulus(1, 1'b1, 1'b1);
    snap = vcount;
    exp_q.push_back(8'hF0);
    send_bits(1, 8'hF0, 1'b1, 8, 0, 2, 1'b0, -1, 1'b1);
    wait_valid("t6_valid_timeout", snap, 20);
    check_output("t6_loopback_data", 32'(rx_data), 32'hF0);
`endif

    // Asynchronous reset in the middle of a frame
    apply_stimulus(5, 1'b1, 1'b0);
    snap = vcount;
    send_bits(5, 8'hFF, 1'b1, 3, 0, 2, 1'b0, -1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_output("t6_rst_rx_data", 32'(rx_data), 32'd0);
    check_output("t6_rst_busy", 32'(busy), 32'd0);
    check_output("t6_rst_sel_active", 32'(sel_active), 32'd0);
    check_output("t6_rst_sel_err", 32'(sel_err), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(12);
    check_output("t6_rst_no_valid", 32'(vcount - snap), 32'd0);
    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
